matmul_nxn_systolic: RTL
========================

# matmul_nxn_systolic

Parametrised N×N output-stationary systolic matrix-multiply core; successor to the fixed 4×4 engine in the matrix_multiplication top. It fetches operand vectors from two synchronous single-read-port RAMs, applies per-row and per-column skew, accumulates C = A·B over a run-time inner dimension, and exposes results through an indexed readout port. Start/done handshake matches the existing top so it can drop in behind the current memory wrappers.

## Interface
- N, 4: array dimension (rows = cols = N), 2..8
- DW, 16: operand element width, unsigned
- ACCW, 32: accumulator/result width, ≥ 2·DW
- AW, 9: operand RAM address width (512 words)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request; sampled in IDLE only
- k_size  in  AW  inner dimension K, sampled with start
- a_base, b_base  in  AW each  base word addresses, sampled with start
- a_addr, b_addr  out  AW each  RAM read addresses, registered
- a_data, b_data  in  N·DW each  RAM read data, 1-cycle read latency; element e at bits [e·DW +: DW]
- busy  out  1  high from accept through completion
- done  out  1  level; high from completion until next accepted start
- out_sel  in  clog2(N·N)  result index i·N+j
- data_out  out  ACCW  selected C[i][j], registered

## Operation
- Storage: A is column-major (word a_base+k = column k of A), B is row-major (word b_base+k = row k of B).
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE: start=1 at edge accepts; latches k_size/bases, clears all N² accumulators and skew pipes, sets busy=1, done=0; goes to FETCH (DRAIN if k_size=0).
- FETCH: one address pair per cycle, k = 0..K-1; a_addr=a_base+k, b_addr=b_base+k, modulo 2^AW (wrap). After K issues → DRAIN.
- Skew: A element i delayed i cycles, B element j delayed j cycles; PE(i,j) forwards A right, B down, accumulates acc += a·b (full 2·DW product, zero-extended to ACCW).
- DRAIN: counts 2N cycles to flush skew pipes and last MAC; → DONE.
- DONE: busy=0, done=1; behaves as IDLE for start acceptance (accept clears done same edge).
- start while busy: ignored, no side effects.
- Accumulators hold results until next accepted start.
- Readout: data_out = acc[out_sel] registered 1 cycle; out_sel ≥ N² → 0. Readout valid in any state; mid-run returns partial sums.
- K=0: no RAM reads issued; results all zero.

## Timing
- Reset values: a_addr=0, b_addr=0, busy=0, done=0, data_out=0, accumulators 0, FSM IDLE.
- Accept edge t0; first address valid after t0; address k presented cycle t0+1+k.
- done rises at edge t0 + K + 2N + 1; busy falls same edge.
- Reset assertion mid-run: immediate abort, all state to reset values; no residual done.
- data_out latency: 1 cycle from out_sel change.

## Configuration
- MATMUL_ACC_SAT_EN defined: each accumulate clamps to 2^ACCW−1 on unsigned overflow and stays saturated.
- Undefined: accumulators wrap modulo 2^ACCW.

## Test plan
- N=4, K=4, A=identity, B[k][j]=4k+j+1 → C equals B; out_sel=5 → 6, out_sel=15 → 16; done at edge t0+13.
- K=1, A column [1,2,3,4], B row [5,6,7,8] → C[0][0]=5, C[3][3]=32, C[2][1]=18.
- K=4, all operands 0xFFFF, ACCW=32 → every C = 0xFFF80004 without macro, 0xFFFFFFFF with MATMUL_ACC_SAT_EN.
- Reset asserted 3 cycles into FETCH → busy=0, done=0, data_out=0 next cycle; fresh start then reproduces test 1 exactly.
- start pulsed during FETCH and DRAIN → ignored, done timing unchanged; a_base=510, K=4 → addresses 510,511,0,1.
- k_size=0 → no addresses change, done at t0+2N+1 = t0+9, all results 0; out_sel ≥ 16 (N=4) → data_out=0.

Source files
------------

// File: rtl/matmul_nxn_systolic.sv
// N x N output-stationary systolic matrix-multiply core with skewed operand feed and indexed readout.
// Optional MATMUL_ACC_SAT_EN: accumulators saturate at 2^ACCW-1 instead of wrapping.
module matmul_nxn_systolic #(
    parameter int unsigned N    = 4,
    parameter int unsigned DW   = 16,
    parameter int unsigned ACCW = 32,
    parameter int unsigned AW   = 9,
    localparam int unsigned SW  = $clog2(N * N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [AW-1:0]     k_size,
    input  logic [AW-1:0]     a_base,
    input  logic [AW-1:0]     b_base,
    output logic [AW-1:0]     a_addr,
    output logic [AW-1:0]     b_addr,
    input  logic [N*DW-1:0]   a_data,
    input  logic [N*DW-1:0]   b_data,
    output logic              busy,
    output logic              done,
    input  logic [SW-1:0]     out_sel,
    output logic [ACCW-1:0]   data_out
);

    localparam int unsigned CW = $clog2(2 * N + 1);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   k_q, k_d;
    logic [AW-1:0]   a_base_q, a_base_d;
    logic [AW-1:0]   b_base_q, b_base_d;
    logic [AW-1:0]   issue_q, issue_d;
    logic [CW-1:0]   drain_q, drain_d;
    logic [AW-1:0]   a_addr_q, a_addr_d;
    logic [AW-1:0]   b_addr_q, b_addr_d;
    logic            rd_v_q, rd_v_d;
    logic [ACCW-1:0] data_out_q;
    logic            clear;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            k_q      <= '0;
            a_base_q <= '0;
            b_base_q <= '0;
            issue_q  <= '0;
            drain_q  <= '0;
            a_addr_q <= '0;
            b_addr_q <= '0;
            rd_v_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            a_base_q <= a_base_d;
            b_base_q <= b_base_d;
            issue_q  <= issue_d;
            drain_q  <= drain_d;
            a_addr_q <= a_addr_d;
            b_addr_q <= b_addr_d;
            rd_v_q   <= rd_v_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        a_base_d = a_base_q;
        b_base_d = b_base_q;
        issue_d  = issue_q;
        drain_d  = drain_q;
        a_addr_d = a_addr_q;
        b_addr_d = b_addr_q;
        clear    = 1'b0;
        // RAM data returns one cycle after each address issued in FETCH
        rd_v_d   = (state_q == StFetch);

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    clear    = 1'b1;
                    k_d      = k_size;
                    a_base_d = a_base;
                    b_base_d = b_base;
                    drain_d  = '0;
                    if (k_size == '0) begin
                        state_d = StDrain;
                    end else begin
                        state_d  = StFetch;
                        a_addr_d = a_base;
                        b_addr_d = b_base;
                        issue_d  = AW'(1);
                    end
                end
            end
            StFetch: begin
                if (issue_q == k_q) begin
                    state_d = StDrain;
                    drain_d = '0;
                end else begin
                    a_addr_d = a_base_q + issue_q;
                    b_addr_d = b_base_q + issue_q;
                    issue_d  = issue_q + AW'(1);
                end
            end
            StDrain: begin
                if (drain_q == CW'(2 * N)) begin
                    state_d = StDone;
                end else begin
                    drain_d = drain_q + CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign a_addr = a_addr_q;
    assign b_addr = b_addr_q;
    assign busy   = (state_q == StFetch) || (state_q == StDrain);
    assign done   = (state_q == StDone);

    // ------------------------------------------------------------------
    // Operand masking and edge skew
    // ------------------------------------------------------------------
    logic [DW-1:0]   a_in  [N];
    logic [DW-1:0]   b_in  [N];
    logic [DW-1:0]   a_row [N];
    logic [DW-1:0]   b_col [N];
    logic [DW-1:0]   a_fwd [N][N-1];
    logic [DW-1:0]   b_fwd [N-1][N];
    logic [ACCW-1:0] acc   [N*N];

    for (genvar e = 0; e < N; e++) begin : g_edge
        assign a_in[e] = rd_v_q ? a_data[e*DW +: DW] : '0;
        assign b_in[e] = rd_v_q ? b_data[e*DW +: DW] : '0;

        if (e == 0) begin : g_noskew
            assign a_row[e] = a_in[e];
            assign b_col[e] = b_in[e];
        end else begin : g_skew
            logic [DW-1:0] a_pipe_q [e];
            logic [DW-1:0] b_pipe_q [e];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int d = 0; d < e; d++) begin
                        a_pipe_q[d] <= '0;
                        b_pipe_q[d] <= '0;
                    end
                end else if (clear) begin
                    for (int d = 0; d < e; d++) begin
                        a_pipe_q[d] <= '0;
                        b_pipe_q[d] <= '0;
                    end
                end else begin
                    a_pipe_q[0] <= a_in[e];
                    b_pipe_q[0] <= b_in[e];
                    for (int d = 1; d < e; d++) begin
                        a_pipe_q[d] <= a_pipe_q[d-1];
                        b_pipe_q[d] <= b_pipe_q[d-1];
                    end
                end
            end

            assign a_row[e] = a_pipe_q[e-1];
            assign b_col[e] = b_pipe_q[e-1];
        end
    end

    // ------------------------------------------------------------------
    // Processing elements: A flows right, B flows down, C stays put
    // ------------------------------------------------------------------
    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [DW-1:0]   a_w;
            logic [DW-1:0]   b_w;
            logic [2*DW-1:0] prod;
            logic [ACCW-1:0] acc_q;
            logic [ACCW-1:0] acc_d;

            if (j == 0) begin : g_a_edge
                assign a_w = a_row[i];
            end else begin : g_a_int
                assign a_w = a_fwd[i][j-1];
            end

            if (i == 0) begin : g_b_edge
                assign b_w = b_col[j];
            end else begin : g_b_int
                assign b_w = b_fwd[i-1][j];
            end

            assign prod = {{DW{1'b0}}, a_w} * {{DW{1'b0}}, b_w};

`ifdef MATMUL_ACC_SAT_EN
            logic [ACCW:0] sum;
            assign sum   = {1'b0, acc_q} + (ACCW + 1)'(prod);
            assign acc_d = sum[ACCW] ? {ACCW{1'b1}} : sum[ACCW-1:0];
`else
            assign acc_d = acc_q + ACCW'(prod);
`endif

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    acc_q <= '0;
                end else if (clear) begin
                    acc_q <= '0;
                end else begin
                    acc_q <= acc_d;
                end
            end

            assign acc[i*N+j] = acc_q;

            if (j < N - 1) begin : g_a_fwd
                logic [DW-1:0] a_fwd_q;
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        a_fwd_q <= '0;
                    end else if (clear) begin
                        a_fwd_q <= '0;
                    end else begin
                        a_fwd_q <= a_w;
                    end
                end
                assign a_fwd[i][j] = a_fwd_q;
            end

            if (i < N - 1) begin : g_b_fwd
                logic [DW-1:0] b_fwd_q;
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        b_fwd_q <= '0;
                    end else if (clear) begin
                        b_fwd_q <= '0;
                    end else begin
                        b_fwd_q <= b_w;
                    end
                end
                assign b_fwd[i][j] = b_fwd_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Indexed readout
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out_q <= '0;
        end else if (32'(out_sel) < N * N) begin
            data_out_q <= acc[out_sel];
        end else begin
            data_out_q <= '0;
        end
    end

    assign data_out = data_out_q;

endmodule
